// File: rtl/dcache_write_buffer.sv
// Coalescing store write buffer for the data cache.
// Circular FIFO with drain port and byte-granular store-to-load forwarding.
module dcache_write_buffer #(
    parameter int PA_WIDTH = 34,
    parameter int DEPTH    = 4,
    parameter int COALESCE = 1
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        enq_valid,
    input  logic [PA_WIDTH-3:0]         enq_addr,
    input  logic [31:0]                 enq_data,
    input  logic [3:0]                  enq_byte_mask,
    output logic                        enq_ready,
    output logic                        drain_valid,
    output logic [PA_WIDTH-3:0]         drain_addr,
    output logic [31:0]                 drain_data,
    output logic [3:0]                  drain_byte_mask,
    input  logic                        drain_ready,
    input  logic [PA_WIDTH-3:0]         fwd_addr,
    input  logic [3:0]                  fwd_byte_mask,
    output logic                        fwd_hit,
    output logic                        fwd_partial,
    output logic [31:0]                 fwd_data,
    output logic [$clog2(DEPTH):0]      occupancy,
    output logic                        empty,
    output logic                        full
);

    localparam int AW = PA_WIDTH - 2;
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [AW-1:0] addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [3:0]    mask_q [DEPTH];

    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [IW-1:0] head_idx;
    logic [IW-1:0] tail_idx;
    logic [IW-1:0] yng_idx;
    logic          coalesce_ok;
    logic          push;
    logic          merge;
    logic          drain_fire;

    assign head_idx = head_q[IW-1:0];
    assign tail_idx = tail_q[IW-1:0];
    assign yng_idx  = tail_idx - IW'(1);

    assign occupancy = tail_q - head_q;
    assign empty     = (head_q == tail_q);
    assign full      = (head_idx == tail_idx) &&
                       (head_q[IW] != tail_q[IW]);

    // Requiring two entries keeps the head, which may be mid-drain, immutable.
    assign coalesce_ok = (COALESCE != 0) &&
                         (occupancy >= PW'(2)) &&
                         (enq_addr == addr_q[yng_idx]);

    assign enq_ready  = !full || coalesce_ok;
    assign merge      = enq_valid && coalesce_ok;
    assign push       = enq_valid && !coalesce_ok && !full;
    assign drain_fire = !empty && drain_ready;

    assign drain_valid     = !empty;
    assign drain_addr      = addr_q[head_idx];
    assign drain_data      = data_q[head_idx];
    assign drain_byte_mask = mask_q[head_idx];

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            head_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                mask_q[i] <= '0;
            end
        end else begin
            if (drain_fire) begin
                head_q <= head_q + PW'(1);
            end
            if (push) begin
                addr_q[tail_idx] <= enq_addr;
                data_q[tail_idx] <= enq_data;
                mask_q[tail_idx] <= enq_byte_mask;
                tail_q           <= tail_q + PW'(1);
            end else if (merge) begin
                for (int b = 0; b < 4; b++) begin
                    if (enq_byte_mask[b]) begin
                        data_q[yng_idx][8*b +: 8] <= enq_data[8*b +: 8];
                    end
                end
                mask_q[yng_idx] <= mask_q[yng_idx] | enq_byte_mask;
            end
        end
    end

    logic [3:0]    fwd_cov;
    logic [IW-1:0] fwd_idx;

    // Walk oldest to youngest so younger matching bytes overwrite older ones.
    always_comb begin
        fwd_cov  = '0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head_idx + IW'(k);
            if ((PW'(k) < occupancy) &&
                (addr_q[fwd_idx] == fwd_addr)) begin
                for (int b = 0; b < 4; b++) begin
                    if (fwd_byte_mask[b] && mask_q[fwd_idx][b]) begin
                        fwd_cov[b]         = 1'b1;
                        fwd_data[8*b +: 8] = data_q[fwd_idx][8*b +: 8];
                    end
                end
            end
        end
        fwd_hit     = (fwd_byte_mask != 4'h0) &&
                      (fwd_cov == fwd_byte_mask);
        fwd_partial = (fwd_cov != 4'h0) &&
                      (fwd_cov != fwd_byte_mask);
    end

endmodule
